gray_window: RTL

GRAY_WINDOW -- requirements
Module: gray_window

---
 rtl/gray_window_pkg.sv | 55 +++++
 rtl/gray_window_line_buffer.sv | 49 ++++
 rtl/gray_window.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/gray_window_pkg.sv
// -----------------------------------------------------------------------------
// gray_window_pkg
// Shared interface types and constants for the gray_window block.
//   dataPort_t : camera pixel stream beat  {valid, data[23:0] = R,G,B}
//   window_t   : 3x3 gray window beat      {valid, data[71:0], cx, cy}
// Also holds the luma coefficients and the helpers used by the datapath.
// -----------------------------------------------------------------------------
package gray_window_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned COL_W   = 24;
  localparam int unsigned WIN_W   = 72;
  // Coordinate fields are sized for the widest supported frame; the block
  // zero-extends its $clog2-wide counters into them.
  localparam int unsigned COORD_W = 16;

  // Integer luma weights; they sum to 256 so a grey input maps to itself.
  localparam logic [15:0] GRAY_KR    = 16'd77;
  localparam logic [15:0] GRAY_KG    = 16'd150;
  localparam logic [15:0] GRAY_KB    = 16'd29;
  localparam int unsigned GRAY_SHIFT = 8;

  typedef struct packed {
    logic             valid;
    logic [RGB_W-1:0] data;
  } dataPort_t;

  typedef struct packed {
    logic               valid;
    logic [WIN_W-1:0]   data;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
  } window_t;

  // RGB888 to 8-bit gray; the weighted sum peaks at 65280, so 16 bits hold it.
  function automatic logic [PIX_W-1:0] rgb_to_gray(input logic [RGB_W-1:0] rgb);
    logic [15:0] sum;
    sum = GRAY_KR * {8'd0, rgb[23:16]}
        + GRAY_KG * {8'd0, rgb[15:8]}
        + GRAY_KB * {8'd0, rgb[7:0]};
    return PIX_W'(sum >> GRAY_SHIFT);
  endfunction

  // Shift a row-major 3x3 window one column left and append a new right
  // column. col is {top, mid, bottom}; the window is p00 in [71:64] down to
  // p22 in [7:0].
  function automatic logic [WIN_W-1:0] shift_window(input logic [WIN_W-1:0] win,
                                                    input logic [COL_W-1:0] col);
    return {win[63:56], win[55:48], col[23:16],
            win[39:32], win[31:24], col[15:8],
            win[15:8],  win[7:0],   col[7:0]};
  endfunction

endpackage

// File: rtl/gray_window_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One line of 8-bit pixels. Single-port, synchronous, read-before-write with
// one cycle of read latency. Contents are never cleared; only the read
// register is reset.
//   clk     : clock
//   rst     : asynchronous active-high reset (read register only)
//   en      : access strobe; a read happens on every enabled cycle
//   we      : write enable, honoured only together with en
//   addr    : pixel column
//   wr_data : value stored at addr
//   rd_data : previous contents of addr, valid the cycle after the access
// -----------------------------------------------------------------------------
module line_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Storage array write; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wr_data;
    end
  end

  // Registered read of the old word at addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (en) begin
      rd_data_r <= mem_r[addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/gray_window.sv
// -----------------------------------------------------------------------------
// gray_window
// Converts an RGB pixel stream to gray and emits a 3x3 gray window for every
// pixel at x >= 2, y >= 2. Free-running three-stage pipeline with a valid
// tag; no stall, no backpressure. A window appears three cycles after the
// input beat of its bottom-right pixel and is centred on (x-1, y-1).
//   clk : clock, all state on its rising edge
//   rst : asynchronous active-high reset
//   in  : dataPort_t pixel stream {valid, R/G/B}
//   out : window_t {valid, data (p00 in [71:64] .. p22 in [7:0]), cx, cy};
//         data/cx/cy hold their last value while valid is low
// Parameters WIDTH and HEIGHT (both >= 3) give pixels per line and lines
// per frame.
// -----------------------------------------------------------------------------
module gray_window
  import gray_window_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  dataPort_t in,
  output window_t   out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(2);
  localparam logic [YW-1:0] Y_MIN  = YW'(2);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  // Position of the next incoming pixel.
  logic [XW-1:0]      x_r;
  logic [YW-1:0]      y_r;

  // Stage 1: gray value and its position.
  logic               v1_r;
  logic [PIX_W-1:0]   g1_r;
  logic [XW-1:0]      x1_r;
  logic [YW-1:0]      y1_r;

  // Stage 2: line-buffer access, gray delayed to line up with the read data.
  logic               v2_r;
  logic [PIX_W-1:0]   g2_r;
  logic [XW-1:0]      x2_r;
  logic [YW-1:0]      y2_r;
  logic               lb0_we_s;
  logic               lb1_we_s;
  logic [PIX_W-1:0]   lb0_rd_s;
  logic [PIX_W-1:0]   lb1_rd_s;

  // Stage 3: window register and output registers.
  logic [COL_W-1:0]   col_s;
  logic [WIN_W-1:0]   win_next_s;
  logic               qualify_s;
  logic [WIN_W-1:0]   win_r;
  logic               out_valid_r;
  logic [WIN_W-1:0]   out_data_r;
  logic [COORD_W-1:0] cx_r;
  logic [COORD_W-1:0] cy_r;

  // Pixel position counters: step on every valid beat, raster order wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
    end else if (in.valid) begin
      if (x_r == X_LAST) begin
        x_r <= {XW{1'b0}};
        if (y_r == Y_LAST) begin
          y_r <= {YW{1'b0}};
        end else begin
          y_r <= y_r + Y_ONE;
        end
      end else begin
        x_r <= x_r + X_ONE;
      end
    end
  end

  // Stage 1: register gray, position and the valid tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r <= 1'b0;
      g1_r <= {PIX_W{1'b0}};
      x1_r <= {XW{1'b0}};
      y1_r <= {YW{1'b0}};
    end else begin
      v1_r <= in.valid;
      if (in.valid) begin
        g1_r <= rgb_to_gray(in.data);
        x1_r <= x_r;
        y1_r <= y_r;
      end
    end
  end

  // The two buffers hold the two previous lines by parity: lb0 keeps even
  // lines, lb1 odd lines. Each access reads both at column x and overwrites
  // the one holding line y-2, which is exactly the buffer of y's parity.
  // Lines 0 and 1 of a frame are always written before line 2 reads them,
  // so no row ever leaks across a frame boundary or a reset.
  always_comb begin
    lb0_we_s = v1_r & ~y1_r[0];
    lb1_we_s = v1_r &  y1_r[0];
  end

  line_buffer #(
    .DEPTH  (WIDTH),
    .DATA_W (PIX_W)
  ) u_lb0 (
    .clk     (clk),
    .rst     (rst),
    .en      (v1_r),
    .we      (lb0_we_s),
    .addr    (x1_r),
    .wr_data (g1_r),
    .rd_data (lb0_rd_s)
  );

  line_buffer #(
    .DEPTH  (WIDTH),
    .DATA_W (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .rst     (rst),
    .en      (v1_r),
    .we      (lb1_we_s),
    .addr    (x1_r),
    .wr_data (g1_r),
    .rd_data (lb1_rd_s)
  );

  // Stage 2: carry gray and position alongside the line-buffer read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r <= 1'b0;
      g2_r <= {PIX_W{1'b0}};
      x2_r <= {XW{1'b0}};
      y2_r <= {YW{1'b0}};
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        g2_r <= g1_r;
        x2_r <= x1_r;
        y2_r <= y1_r;
      end
    end
  end

  // New window column {top, mid, bottom}; top is the buffer of y's parity.
  always_comb begin
    col_s      = {COL_W{1'b0}};
    if (y2_r[0]) begin
      col_s = {lb1_rd_s, lb0_rd_s, g2_r};
    end else begin
      col_s = {lb0_rd_s, lb1_rd_s, g2_r};
    end
    win_next_s = shift_window(win_r, col_s);
    qualify_s  = v2_r && (x2_r >= X_MIN) && (y2_r >= Y_MIN);
  end

  // Stage 3: shift the window on every valid tag; publish qualifying ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_r       <= {WIN_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIN_W{1'b0}};
      cx_r        <= {COORD_W{1'b0}};
      cy_r        <= {COORD_W{1'b0}};
    end else begin
      out_valid_r <= qualify_s;
      if (v2_r) begin
        win_r <= win_next_s;
      end
      if (qualify_s) begin
        out_data_r <= win_next_s;
        cx_r       <= COORD_W'(x2_r - X_ONE);
        cy_r       <= COORD_W'(y2_r - Y_ONE);
      end
    end
  end

  assign out = '{valid: out_valid_r, data: out_data_r, cx: cx_r, cy: cy_r};

endmodule
